// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive and transmit blocks.
//   uart_state_t : one-hot receiver states IDLE/START/DATA/STOP
//   uart_frame_t : one 8N1 frame as it appears on the wire. Bit 0 is the start bit,
//                  bits 8:1 are the payload (LSB first) and bit 9 is the stop bit.
//   baud_width() : clock cycles per line bit
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_t;

  typedef struct packed {
    logic                 stop_bit;
    logic [DATA_BITS-1:0] payload;
    logic                 start_bit;
  } uart_frame_t;

  function automatic int baud_width(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input.
//   clk : sampling clock
//   rst : synchronous active-high reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output, two cycles behind d
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ready output buffer.
//   clk        : single clock, all logic on posedge
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   data_out   : received byte, stable while data_valid is high
//   data_valid : byte available, held until accepted
//   data_ready : consumer accept; transfer when data_valid && data_ready
//   frame_err  : one-cycle pulse when the stop bit is sampled low (byte discarded)
//   overrun    : one-cycle pulse when a byte completes while the buffer is full (byte dropped)
//   rx_busy    : high whenever the receiver is not idle
// The far-end transmitter sends the payload inverted; INVERT_PAYLOAD=1 undoes that.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCK_SPEED    = 50_000_000,
  parameter bit INVERT_PAYLOAD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CNT_W      = $clog2(BAUD_WIDTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2:0]           bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 armed_reg;
  logic [DATA_BITS-1:0] data_out_reg;
  logic                 data_valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
  logic                 rx_busy_reg;

  logic                 sample;
  logic                 stop_good;
  logic                 stop_bad;
  logic [DATA_BITS-1:0] payload;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next state; 'sample' marks the cycle in which rx_s is taken as the bit value.
  always_comb begin
    state_next = state_reg;
    sample     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A start is only accepted after the line has been seen high, so a
        // held-low line (break) does not produce repeated framing errors.
        if (armed_reg && !rx_s) state_next = ST_START;
      end
      ST_START: begin
        if (cnt_reg == HALF_LAST) begin
          sample     = 1'b1;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == BAUD_LAST) begin
          sample = 1'b1;
          if (bit_idx_reg == LAST_BIT) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_reg == BAUD_LAST) begin
          sample     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign stop_good = (state_reg == ST_STOP) && sample && rx_s;
  assign stop_bad  = (state_reg == ST_STOP) && sample && !rx_s;
  assign payload   = INVERT_PAYLOAD ? ~shift_reg : shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      armed_reg      <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      rx_busy_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Counter restarts on every state change and after every mid-bit sample.
      if (state_reg == ST_IDLE || state_next != state_reg || sample)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;

      if (state_reg == ST_START && sample)
        bit_idx_reg <= '0;
      else if (state_reg == ST_DATA && sample)
        bit_idx_reg <= bit_idx_reg + 1'b1;

      // LSB arrives first: shift right, new bit enters at the MSB.
      if (state_reg == ST_DATA && sample)
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};

      if (stop_bad)
        armed_reg <= 1'b0;
      else if (rx_s)
        armed_reg <= 1'b1;

      frame_err_reg <= stop_bad;
      overrun_reg   <= 1'b0;

      // One-entry buffer: a same-cycle accept frees the slot for the new byte.
      if (stop_good && (!data_valid_reg || data_ready)) begin
        data_out_reg   <= payload;
        data_valid_reg <= 1'b1;
      end else if (stop_good) begin
        overrun_reg <= 1'b1;
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end

      rx_busy_reg <= (state_next != ST_IDLE);
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign rx_busy    = rx_busy_reg;

endmodule
